// File: rtl/video_timing_pkg.sv
// Shared types, colour constants and default 720p raster timing for the video timing generator.
// Colours are packed {B[23:16], G[15:8], R[7:0]} to match the TMDS encoder lane order.
package video_timing_pkg;

    typedef enum logic [1:0] {
        BARS     = 2'd0,
        GRADIENT = 2'd1,
        CHECKER  = 2'd2,
        BORDER   = 2'd3
    } pattern_e;

    localparam logic [23:0] WHITE   = 24'hFF_FF_FF;
    localparam logic [23:0] YELLOW  = 24'h00_FF_FF;
    localparam logic [23:0] CYAN    = 24'hFF_FF_00;
    localparam logic [23:0] GREEN   = 24'h00_FF_00;
    localparam logic [23:0] MAGENTA = 24'hFF_00_FF;
    localparam logic [23:0] RED     = 24'h00_00_FF;
    localparam logic [23:0] BLUE    = 24'hFF_00_00;
    localparam logic [23:0] BLACK   = 24'h00_00_00;

    localparam int H_ACTIVE_720 = 1280;
    localparam int H_FP_720     = 110;
    localparam int H_SYNC_720   = 40;
    localparam int H_BP_720     = 220;
    localparam int V_ACTIVE_720 = 720;
    localparam int V_FP_720     = 5;
    localparam int V_SYNC_720   = 5;
    localparam int V_BP_720     = 20;

endpackage

// File: rtl/video_timing_gen_pattern_gen.sv
// Combinational test-pattern colour lookup for one pixel.
// Latency: none (pure lookup); no backpressure.
module pattern_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_720,
    parameter int V_ACTIVE = V_ACTIVE_720
) (
    input  logic [15:0] i_x,
    input  logic [15:0] i_y,
    input  logic [7:0]  i_frame,
    input  pattern_e    i_pattern,
    input  logic [2:0]  i_bar_idx,
    output logic [23:0] o_rgb
);

    localparam logic [15:0] X_LAST = 16'(H_ACTIVE - 1);
    localparam logic [15:0] Y_LAST = 16'(V_ACTIVE - 1);

    always_comb begin
        o_rgb = BLACK;
        unique case (i_pattern)
            BARS: begin
                unique case (i_bar_idx)
                    3'd0:    o_rgb = WHITE;
                    3'd1:    o_rgb = YELLOW;
                    3'd2:    o_rgb = CYAN;
                    3'd3:    o_rgb = GREEN;
                    3'd4:    o_rgb = MAGENTA;
                    3'd5:    o_rgb = RED;
                    3'd6:    o_rgb = BLUE;
                    default: o_rgb = BLACK;
                endcase
            end
            GRADIENT: o_rgb = {i_frame, i_y[7:0], i_x[7:0]};
            CHECKER:  o_rgb = (i_x[5] ^ i_y[5]) ? WHITE : BLACK;
            BORDER: begin
                if (i_x == 16'd0 || i_x == X_LAST || i_y == 16'd0 || i_y == Y_LAST)
                    o_rgb = WHITE;
            end
            default: o_rgb = BLACK;
        endcase
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster counters, sync decode and registered {de,vsync,hsync}/RGB/frame outputs for HDMI.
// Latency: 1 cycle from counter to outputs; free-running, no backpressure.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int   H_ACTIVE  = H_ACTIVE_720,
    parameter int   H_FP      = H_FP_720,
    parameter int   H_SYNC    = H_SYNC_720,
    parameter int   H_BP      = H_BP_720,
    parameter int   V_ACTIVE  = V_ACTIVE_720,
    parameter int   V_FP      = V_FP_720,
    parameter int   V_SYNC    = V_SYNC_720,
    parameter int   V_BP      = V_BP_720,
    parameter logic HSYNC_POL = 1'b1,
    parameter logic VSYNC_POL = 1'b1
) (
    input  logic        i_hdmi_clk,
    input  logic        i_reset_n,
    input  logic [1:0]  i_pattern,
    output logic [2:0]  o_hve_sync,
    output logic [23:0] o_rgb,
    output logic [7:0]  o_frame,
    output logic        o_frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

    localparam logic [31:0] H_ACT_U  = H_ACTIVE;
    localparam logic [31:0] V_ACT_U  = V_ACTIVE;
    localparam logic [31:0] H_SYNC_S = H_ACTIVE + H_FP;
    localparam logic [31:0] H_SYNC_E = H_ACTIVE + H_FP + H_SYNC;
    localparam logic [31:0] V_SYNC_S = V_ACTIVE + V_FP;
    localparam logic [31:0] V_SYNC_E = V_ACTIVE + V_FP + V_SYNC;

    logic [HW-1:0] r_h;
    logic [VW-1:0] r_v;
    logic [BW-1:0] r_bar_cnt;
    logic [2:0]    r_bar_idx;
    logic [7:0]    r_frame_cnt;
    pattern_e      r_pattern;

    logic          w_h_last;
    logic          w_v_last;
    logic          w_origin;
    logic          w_de;
    logic          w_hs_on;
    logic          w_vs_on;
    pattern_e      w_pattern;
    logic [23:0]   w_rgb;

    assign w_h_last = (r_h == H_LAST);
    assign w_v_last = (r_v == V_LAST);
    assign w_origin = (r_h == '0) && (r_v == '0);
    assign w_de     = (32'(r_h) < H_ACT_U) && (32'(r_v) < V_ACT_U);
    assign w_hs_on  = (32'(r_h) >= H_SYNC_S) && (32'(r_h) < H_SYNC_E);
    assign w_vs_on  = (32'(r_v) >= V_SYNC_S) && (32'(r_v) < V_SYNC_E);

    // Pixel (0,0) already uses the freshly sampled pattern so a whole frame is uniform.
    assign w_pattern = w_origin ? pattern_e'(i_pattern) : r_pattern;

    pattern_gen #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_pattern_gen (
        .i_x       (16'(r_h)),
        .i_y       (16'(r_v)),
        .i_frame   (r_frame_cnt),
        .i_pattern (w_pattern),
        .i_bar_idx (r_bar_idx),
        .o_rgb     (w_rgb)
    );

    // Bar index tracks r_h via a width sub-counter, avoiding a divide by BAR_W.
    always_ff @(posedge i_hdmi_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_h         <= '0;
            r_v         <= '0;
            r_bar_cnt   <= '0;
            r_bar_idx   <= '0;
            r_frame_cnt <= '0;
            r_pattern   <= BARS;
        end else begin
            if (w_h_last) begin
                r_h       <= '0;
                r_bar_cnt <= '0;
                r_bar_idx <= '0;
                r_v       <= w_v_last ? '0 : r_v + 1'b1;
            end else begin
                r_h <= r_h + 1'b1;
                if (r_bar_cnt == BAR_LAST) begin
                    r_bar_cnt <= '0;
                    r_bar_idx <= r_bar_idx + 1'b1;
                end else begin
                    r_bar_cnt <= r_bar_cnt + 1'b1;
                end
            end
            if (w_h_last && w_v_last)
                r_frame_cnt <= r_frame_cnt + 8'd1;
            r_pattern <= w_pattern;
        end
    end

    always_ff @(posedge i_hdmi_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_hve_sync    <= {1'b0, ~VSYNC_POL, ~HSYNC_POL};
            o_rgb         <= '0;
            o_frame       <= '0;
            o_frame_start <= 1'b0;
        end else begin
            o_hve_sync    <= {w_de,
                              w_vs_on ? VSYNC_POL : ~VSYNC_POL,
                              w_hs_on ? HSYNC_POL : ~HSYNC_POL};
            o_rgb         <= w_de ? w_rgb : 24'd0;
            o_frame       <= r_frame_cnt;
            o_frame_start <= w_origin;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen at a 24x12 raster; second instance has active-low hsync.
module tb_video_timing_gen;

    localparam int HT = 24;
    localparam int FT = 288;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rst_b_n;
    logic [1:0]  pat;
    logic [1:0]  pat_b;
    logic [2:0]  hve,  hve_b;
    logic [23:0] rgb,  rgb_b;
    logic [7:0]  frm,  frm_b;
    logic        fs,   fs_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(4),
        .V_ACTIVE(8),  .V_FP(1), .V_SYNC(1), .V_BP(2),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
    ) dut (
        .i_hdmi_clk(clk), .i_reset_n(rst_n), .i_pattern(pat),
        .o_hve_sync(hve), .o_rgb(rgb), .o_frame(frm), .o_frame_start(fs)
    );

    video_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(4),
        .V_ACTIVE(8),  .V_FP(1), .V_SYNC(1), .V_BP(2),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b1)
    ) dut_n (
        .i_hdmi_clk(clk), .i_reset_n(rst_b_n), .i_pattern(pat_b),
        .o_hve_sync(hve_b), .o_rgb(rgb_b), .o_frame(frm_b), .o_frame_start(fs_b)
    );

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic int cyc_of(input int f, input int x, input int y);
        return f * FT + y * HT + x + 1;
    endfunction

    logic [23:0] bars [8];
    int hs_rise[$];
    int vs_rise[$];
    int fs_cyc[$];
    int hs_cnt = 0;
    int vs_cnt = 0;
    int bad_iv = 0;
    logic prev_hs = 1'b0;
    logic prev_vs = 1'b0;

    initial begin
        bars[0] = 24'hFFFFFF; bars[1] = 24'h00FFFF; bars[2] = 24'hFFFF00; bars[3] = 24'h00FF00;
        bars[4] = 24'hFF00FF; bars[5] = 24'h0000FF; bars[6] = 24'hFF0000; bars[7] = 24'h000000;

        rst_n = 1'b0; rst_b_n = 1'b0; pat = 2'd0; pat_b = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_eq("rst_hve",   32'(hve),   32'h0);
        chk_eq("rst_rgb",   32'(rgb),   32'h0);
        chk_eq("rst_frame", 32'(frm),   32'h0);
        chk_eq("rst_fs",    32'(fs),    32'h0);
        chk_eq("rst_hve_n", 32'(hve_b), 32'h1);
        rst_n = 1'b1; rst_b_n = 1'b1;

        for (int c = 1; c <= 4 * FT; c++) begin
            @(negedge clk);
            if (c <= 2 * FT) begin
                hs_cnt += int'(hve[0]);
                vs_cnt += int'(hve[1]);
                if (hve[0] && !prev_hs) hs_rise.push_back(c);
                if (hve[1] && !prev_vs) vs_rise.push_back(c);
                if (fs) fs_cyc.push_back(c);
                prev_hs = hve[0];
                prev_vs = hve[1];
            end

            if (c == 1) begin
                chk_eq("first_fs",  32'(fs),  32'h1);
                chk_eq("first_hve", 32'(hve), 32'h4);
                chk_eq("first_frm", 32'(frm), 32'h0);
            end
            if (c <= 16)
                chk_eq($sformatf("bars_x%0d", c - 1), 32'(rgb), 32'(bars[(c - 1) / 2]));
            else if (c <= HT) begin
                chk_eq($sformatf("blank_rgb_x%0d", c - 1), 32'(rgb), 32'h0);
                chk_eq($sformatf("blank_de_x%0d", c - 1), 32'(hve[2]), 32'h0);
            end

            if (c == cyc_of(0, 0, 5)) chk_eq("bars_hold_0_5", 32'(rgb), 32'hFFFFFF);
            if (c == cyc_of(0, 3, 7)) chk_eq("bars_hold_3_7", 32'(rgb), 32'h00FFFF);
            if (c == FT)              chk_eq("frm_before_wrap", 32'(frm), 32'h0);
            if (c == FT + 1) begin
                chk_eq("frm_after_wrap", 32'(frm), 32'h1);
                chk_eq("chk_origin_rgb", 32'(rgb), 32'h0);
                chk_eq("chk_origin_hve", 32'(hve), 32'h4);
            end
            if (c == cyc_of(1, 5, 3))  chk_eq("chk_5_3", 32'(rgb), 32'h0);
            if (c == cyc_of(2, 5, 3)) begin
                chk_eq("grad_5_3", 32'(rgb), 32'h020305);
                chk_eq("grad_frm", 32'(frm), 32'h2);
            end
            if (c == cyc_of(2, 15, 7)) chk_eq("grad_15_7", 32'(rgb), 32'h02070F);
            if (c == cyc_of(3, 0, 3))  chk_eq("bord_0_3",  32'(rgb), 32'hFFFFFF);
            if (c == cyc_of(3, 15, 3)) chk_eq("bord_15_3", 32'(rgb), 32'hFFFFFF);
            if (c == cyc_of(3, 7, 0))  chk_eq("bord_7_0",  32'(rgb), 32'hFFFFFF);
            if (c == cyc_of(3, 7, 7))  chk_eq("bord_7_7",  32'(rgb), 32'hFFFFFF);
            if (c == cyc_of(3, 1, 1))  chk_eq("bord_1_1",  32'(rgb), 32'h0);
            if (c == cyc_of(3, 16, 0)) chk_eq("bord_hblank", 32'(rgb), 32'h0);
            if (c == cyc_of(3, 0, 8))  chk_eq("bord_vblank", 32'(rgb), 32'h0);
            if (c == cyc_of(3, 0, 0))  chk_eq("frm3", 32'(frm), 32'h3);

            if (c == 18) chk_eq("n_hs_idle",   32'(hve_b), 32'h1);
            if (c == 19) chk_eq("n_hs_active", 32'(hve_b), 32'h0);
            if (c == cyc_of(0, 10, 5)) begin
                chk_eq("n_pre_hve", 32'(hve_b), 32'h5);
                chk_eq("n_pre_rgb", 32'(rgb_b), 32'h0000FF);
                rst_b_n = 1'b0;
                #1;
                chk_eq("n_rst_hve", 32'(hve_b), 32'h1);
                chk_eq("n_rst_rgb", 32'(rgb_b), 32'h0);
                chk_eq("n_rst_fs",  32'(fs_b),  32'h0);
            end
            if (c == cyc_of(0, 10, 5) + 2) rst_b_n = 1'b1;
            if (c == cyc_of(0, 10, 5) + 3) begin
                chk_eq("n_restart_hve", 32'(hve_b), 32'h5);
                chk_eq("n_restart_fs",  32'(fs_b),  32'h1);
                chk_eq("n_restart_frm", 32'(frm_b), 32'h0);
                chk_eq("n_restart_rgb", 32'(rgb_b), 32'hFFFFFF);
            end
            if (c == cyc_of(0, 10, 5) + 4) chk_eq("n_restart_fs_off", 32'(fs_b), 32'h0);

            if (c == cyc_of(0, 4, 4) - 1) pat = 2'd2;
            if (c == cyc_of(1, 4, 4) - 1) pat = 2'd1;
            if (c == cyc_of(2, 4, 4) - 1) pat = 2'd3;
        end

        chk_eq("hs_high_cycles", 32'(hs_cnt), 32'd48);
        chk_eq("vs_high_cycles", 32'(vs_cnt), 32'd48);
        chk_eq("hs_rise_count",  32'(hs_rise.size()), 32'd24);
        chk_eq("hs_first_rise",  32'((hs_rise.size() > 0) ? hs_rise[0] : -1), 32'd19);
        for (int i = 1; i < hs_rise.size(); i++)
            if (hs_rise[i] - hs_rise[i - 1] != HT) bad_iv++;
        chk_eq("hs_period_errs", 32'(bad_iv), 32'd0);
        chk_eq("vs_rise_count",  32'(vs_rise.size()), 32'd2);
        chk_eq("vs_rise0", 32'((vs_rise.size() > 0) ? vs_rise[0] : -1), 32'd217);
        chk_eq("vs_rise1", 32'((vs_rise.size() > 1) ? vs_rise[1] : -1), 32'd505);
        chk_eq("fs_count", 32'(fs_cyc.size()), 32'd2);
        chk_eq("fs_cyc0",  32'((fs_cyc.size() > 0) ? fs_cyc[0] : -1), 32'd1);
        chk_eq("fs_cyc1",  32'((fs_cyc.size() > 1) ? fs_cyc[1] : -1), 32'd289);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
